// File: rtl/mem_req_arbiter_rr.sv
// Two-source round-robin request arbiter feeding an in-order latency injector.
// An order FIFO remembers which source issued each request so responses can be routed back.
module mem_req_arbiter_rr #(
    parameter int ORDER_DEPTH = 8,
    parameter int CW          = $clog2(ORDER_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s0_req_valid,
    input  logic          s0_req_is_dram,
    input  logic [15:0]   s0_req_size_bytes,
    output logic          s0_req_ready,
    input  logic          s1_req_valid,
    input  logic          s1_req_is_dram,
    input  logic [15:0]   s1_req_size_bytes,
    output logic          s1_req_ready,
    output logic          m_req_valid,
    output logic          m_req_is_dram,
    output logic [15:0]   m_req_size_bytes,
    input  logic          m_req_ready,
    input  logic          m_resp_valid,
    input  logic [15:0]   m_resp_size_bytes,
    output logic          s0_resp_valid,
    output logic [15:0]   s0_resp_size_bytes,
    output logic          s1_resp_valid,
    output logic [15:0]   s1_resp_size_bytes,
    output logic [CW-1:0] outstanding,
    output logic [31:0]   grant0_count,
    output logic [31:0]   grant1_count,
    output logic [31:0]   resp_underflow_count,
    output logic [31:0]   size_mismatch_count
);
    localparam int AW = $clog2(ORDER_DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(ORDER_DEPTH);

    logic [CW-1:0] r_count;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic          r_last_grant;
    logic          r_mem_src  [ORDER_DEPTH];
    logic [15:0]   r_mem_size [ORDER_DEPTH];
    logic          r_head_src;
    logic [15:0]   r_head_size;
    logic          r_pop_d;
    logic [15:0]   r_resp_size_d;
    logic [31:0]   r_grant0_cnt;
    logic [31:0]   r_grant1_cnt;
    logic [31:0]   r_underflow_cnt;
    logic [31:0]   r_mismatch_cnt;

    logic          w_full;
    logic          w_any_valid;
    logic          w_grant_src;
    logic          w_push;
    logic          w_pop;
    logic          w_underflow;
    logic [1:0]    w_req_ready;
    logic [1:0]    w_resp_valid;
    logic [15:0]   w_resp_size [2];

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        w_full           = (r_count == FULL_CNT);
        w_any_valid      = s0_req_valid | s1_req_valid;
        w_grant_src      = (s0_req_valid & s1_req_valid) ? ~r_last_grant : s1_req_valid;
        m_req_valid      = w_any_valid & ~w_full;
        m_req_is_dram    = 1'b0;
        m_req_size_bytes = '0;
        if (w_any_valid) begin
            m_req_is_dram    = w_grant_src ? s1_req_is_dram    : s0_req_is_dram;
            m_req_size_bytes = w_grant_src ? s1_req_size_bytes : s0_req_size_bytes;
        end
        w_push      = m_req_valid & m_req_ready;
        w_pop       = m_resp_valid & (r_count != '0);
        w_underflow = m_resp_valid & (r_count == '0);
    end

    // Response routing uses the head entry read out on the pop edge, so the
    // pulse appears exactly one cycle after m_resp_valid.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign w_req_ready[gi]  = m_req_ready & ~w_full & w_any_valid & (w_grant_src == 1'(gi));
            assign w_resp_valid[gi] = r_pop_d & (r_head_src == 1'(gi));
            assign w_resp_size[gi]  = w_resp_valid[gi] ? r_resp_size_d : '0;
        end
    endgenerate

    assign s0_req_ready         = w_req_ready[0];
    assign s1_req_ready         = w_req_ready[1];
    assign s0_resp_valid        = w_resp_valid[0];
    assign s1_resp_valid        = w_resp_valid[1];
    assign s0_resp_size_bytes   = w_resp_size[0];
    assign s1_resp_size_bytes   = w_resp_size[1];
    assign outstanding          = r_count;
    assign grant0_count         = r_grant0_cnt;
    assign grant1_count         = r_grant1_cnt;
    assign resp_underflow_count = r_underflow_cnt;
    assign size_mismatch_count  = r_mismatch_cnt;

    // Storage is left unreset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_src[r_wr_ptr]  <= w_grant_src;
            r_mem_size[r_wr_ptr] <= m_req_size_bytes;
        end
        r_head_src  <= r_mem_src[r_rd_ptr];
        r_head_size <= r_mem_size[r_rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count         <= '0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_last_grant    <= 1'b1;
            r_pop_d         <= 1'b0;
            r_resp_size_d   <= '0;
            r_grant0_cnt    <= '0;
            r_grant1_cnt    <= '0;
            r_underflow_cnt <= '0;
            r_mismatch_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr     <= r_wr_ptr + AW'(1);
                r_last_grant <= w_grant_src;
                if (w_grant_src) r_grant1_cnt <= sat_inc(r_grant1_cnt);
                else             r_grant0_cnt <= sat_inc(r_grant0_cnt);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
            r_pop_d       <= w_pop;
            r_resp_size_d <= m_resp_size_bytes;
            if (w_underflow) r_underflow_cnt <= sat_inc(r_underflow_cnt);
            if (r_pop_d && (r_head_size != r_resp_size_d))
                r_mismatch_cnt <= sat_inc(r_mismatch_cnt);
        end
    end
endmodule

// File: tb/tb_mem_req_arbiter_rr.sv
// Directed, table-driven bench for mem_req_arbiter_rr with hand-written
// sequences for counter state, underflow and mid-operation reset.
module tb_mem_req_arbiter_rr;
    logic        clk;
    logic        reset;
    logic        s0_req_valid, s0_req_is_dram, s0_req_ready;
    logic [15:0] s0_req_size_bytes;
    logic        s1_req_valid, s1_req_is_dram, s1_req_ready;
    logic [15:0] s1_req_size_bytes;
    logic        m_req_valid, m_req_is_dram, m_req_ready;
    logic [15:0] m_req_size_bytes;
    logic        m_resp_valid;
    logic [15:0] m_resp_size_bytes;
    logic        s0_resp_valid, s1_resp_valid;
    logic [15:0] s0_resp_size_bytes, s1_resp_size_bytes;
    logic [3:0]  outstanding;
    logic [31:0] grant0_count, grant1_count, resp_underflow_count, size_mismatch_count;

    int n_pass  = 0;
    int n_total = 0;

    mem_req_arbiter_rr #(.ORDER_DEPTH(8)) dut (
        .clk(clk), .reset(reset),
        .s0_req_valid(s0_req_valid), .s0_req_is_dram(s0_req_is_dram),
        .s0_req_size_bytes(s0_req_size_bytes), .s0_req_ready(s0_req_ready),
        .s1_req_valid(s1_req_valid), .s1_req_is_dram(s1_req_is_dram),
        .s1_req_size_bytes(s1_req_size_bytes), .s1_req_ready(s1_req_ready),
        .m_req_valid(m_req_valid), .m_req_is_dram(m_req_is_dram),
        .m_req_size_bytes(m_req_size_bytes), .m_req_ready(m_req_ready),
        .m_resp_valid(m_resp_valid), .m_resp_size_bytes(m_resp_size_bytes),
        .s0_resp_valid(s0_resp_valid), .s0_resp_size_bytes(s0_resp_size_bytes),
        .s1_resp_valid(s1_resp_valid), .s1_resp_size_bytes(s1_resp_size_bytes),
        .outstanding(outstanding),
        .grant0_count(grant0_count), .grant1_count(grant1_count),
        .resp_underflow_count(resp_underflow_count),
        .size_mismatch_count(size_mismatch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          seg;
        logic        s0v, s0d;
        logic [15:0] s0sz;
        logic        s1v, s1d;
        logic [15:0] s1sz;
        logic        mrdy, rv;
        logic [15:0] rsz;
        logic        e_mv, e_r0, e_r1, e_dram;
        logic [15:0] e_msz;
        logic        e_v0, e_v1;
        logic [15:0] e_sz0, e_sz1;
        int          e_out;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input int seg,
                           input logic s0v, input logic s0d, input logic [15:0] s0sz,
                           input logic s1v, input logic s1d, input logic [15:0] s1sz,
                           input logic mrdy, input logic rv, input logic [15:0] rsz,
                           input logic e_mv, input logic e_r0, input logic e_r1,
                           input logic e_dram, input logic [15:0] e_msz,
                           input logic e_v0, input logic e_v1,
                           input logic [15:0] e_sz0, input logic [15:0] e_sz1,
                           input int e_out);
        vec_t v;
        v.seg = seg;
        v.s0v = s0v; v.s0d = s0d; v.s0sz = s0sz;
        v.s1v = s1v; v.s1d = s1d; v.s1sz = s1sz;
        v.mrdy = mrdy; v.rv = rv; v.rsz = rsz;
        v.e_mv = e_mv; v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_dram = e_dram; v.e_msz = e_msz;
        v.e_v0 = e_v0; v.e_v1 = e_v1; v.e_sz0 = e_sz0; v.e_sz1 = e_sz1; v.e_out = e_out;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive_idle();
        s0_req_valid = 0; s0_req_is_dram = 0; s0_req_size_bytes = 0;
        s1_req_valid = 0; s1_req_is_dram = 0; s1_req_size_bytes = 0;
        m_req_ready = 0; m_resp_valid = 0; m_resp_size_bytes = 0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        drive_idle();
        #2;
    endtask

    task automatic run_seg(input int seg);
        foreach (vecs[i]) begin
            if (vecs[i].seg == seg) begin
                @(negedge clk);
                s0_req_valid = vecs[i].s0v; s0_req_is_dram = vecs[i].s0d; s0_req_size_bytes = vecs[i].s0sz;
                s1_req_valid = vecs[i].s1v; s1_req_is_dram = vecs[i].s1d; s1_req_size_bytes = vecs[i].s1sz;
                m_req_ready = vecs[i].mrdy; m_resp_valid = vecs[i].rv; m_resp_size_bytes = vecs[i].rsz;
                #2;
                check($sformatf("v%0d.m_req_valid", i), 32'(m_req_valid), 32'(vecs[i].e_mv));
                check($sformatf("v%0d.s0_req_ready", i), 32'(s0_req_ready), 32'(vecs[i].e_r0));
                check($sformatf("v%0d.s1_req_ready", i), 32'(s1_req_ready), 32'(vecs[i].e_r1));
                check($sformatf("v%0d.m_req_is_dram", i), 32'(m_req_is_dram), 32'(vecs[i].e_dram));
                check($sformatf("v%0d.m_req_size", i), 32'(m_req_size_bytes), 32'(vecs[i].e_msz));
                check($sformatf("v%0d.s0_resp_valid", i), 32'(s0_resp_valid), 32'(vecs[i].e_v0));
                check($sformatf("v%0d.s1_resp_valid", i), 32'(s1_resp_valid), 32'(vecs[i].e_v1));
                check($sformatf("v%0d.s0_resp_size", i), 32'(s0_resp_size_bytes), 32'(vecs[i].e_sz0));
                check($sformatf("v%0d.s1_resp_size", i), 32'(s1_resp_size_bytes), 32'(vecs[i].e_sz1));
                check($sformatf("v%0d.outstanding", i), 32'(outstanding), 32'(vecs[i].e_out));
                $display("vec %0d seg %0d: m_req_valid=%0d rdy=%0d%0d out=%0d resp=%0d%0d",
                         i, seg, m_req_valid, s0_req_ready, s1_req_ready, outstanding,
                         s0_resp_valid, s1_resp_valid);
            end
        end
    endtask

    initial begin
        // seg 1: both sources contend until full, then a response arrives while full
        for (int k = 0; k < 8; k++)
            add_vec(1, 1, 1, 16, 1, 0, 32, 1, 0, 0,
                    1, (k % 2 == 0), (k % 2 == 1), (k % 2 == 0), (k % 2 == 0) ? 16'd16 : 16'd32,
                    0, 0, 0, 0, k);
        add_vec(1, 1, 1, 16, 1, 0, 32, 1, 1, 16, 0, 0, 0, 1, 16, 0, 0, 0, 0, 8);
        add_vec(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16, 0, 7);
        // seg 2: drain remaining seven entries (src 1,0,1,0,1,0,1); second response has a bad size
        for (int d = 0; d < 8; d++) begin
            int rsz, psz;
            rsz = (d == 1) ? 99 : ((d % 2 == 0) ? 32 : 16);
            psz = (d == 2) ? 99 : (((d - 1) % 2 == 0) ? 32 : 16);
            add_vec(2, 0, 0, 0, 0, 0, 0, 1, (d < 7), (d < 7) ? 16'(rsz) : 16'd0,
                    0, 0, 0, 0, 0,
                    (d > 0) && ((d - 1) % 2 == 1), (d > 0) && ((d - 1) % 2 == 0),
                    ((d > 0) && ((d - 1) % 2 == 1)) ? 16'(psz) : 16'd0,
                    ((d > 0) && ((d - 1) % 2 == 0)) ? 16'(psz) : 16'd0,
                    7 - d);
        end
        // seg 3: response with empty FIFO
        add_vec(3, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_vec(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // seg 4: push into empty FIFO alongside a response, then a size-mismatched response
        add_vec(4, 0, 0, 0, 1, 1, 96, 1, 1, 7, 1, 0, 1, 1, 96, 0, 0, 0, 0, 0);
        add_vec(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add_vec(4, 0, 0, 0, 0, 0, 0, 0, 1, 48, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add_vec(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 48, 0);
        add_vec(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // seg 5: stalled grant held, then five transfers
        for (int h = 0; h < 2; h++)
            add_vec(5, 1, 0, 8, 1, 1, 24, 0, 0, 0, 1, 0, 0, 0, 8, 0, 0, 0, 0, 0);
        for (int j = 0; j < 5; j++)
            add_vec(5, 1, 0, 8, 1, 1, 24, 1, 0, 0,
                    1, (j % 2 == 0), (j % 2 == 1), (j % 2 == 1), (j % 2 == 1) ? 16'd24 : 16'd8,
                    0, 0, 0, 0, j);
        // seg 6: response right after a mid-operation reset
        add_vec(6, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_vec(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        drive_idle();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("rst.outstanding", 32'(outstanding), 0);
        check("rst.s0_resp_valid", 32'(s0_resp_valid), 0);
        check("rst.s1_resp_valid", 32'(s1_resp_valid), 0);
        check("rst.s0_resp_size", 32'(s0_resp_size_bytes), 0);
        check("rst.s1_resp_size", 32'(s1_resp_size_bytes), 0);
        check("rst.grant0", grant0_count, 0);
        check("rst.grant1", grant1_count, 0);
        check("rst.underflow", resp_underflow_count, 0);
        check("rst.mismatch", size_mismatch_count, 0);
        reset = 1'b0;

        run_seg(1);
        idle_cycle();
        check("full.grant0", grant0_count, 4);
        check("full.grant1", grant1_count, 4);
        check("full.mismatch", size_mismatch_count, 0);
        check("full.underflow", resp_underflow_count, 0);

        run_seg(2);
        idle_cycle();
        check("drain.mismatch", size_mismatch_count, 1);
        check("drain.outstanding", 32'(outstanding), 0);

        run_seg(3);
        idle_cycle();
        check("empty.underflow", resp_underflow_count, 1);

        run_seg(4);
        idle_cycle();
        check("pushpop.underflow", resp_underflow_count, 2);
        check("pushpop.mismatch", size_mismatch_count, 2);
        check("pushpop.grant0", grant0_count, 4);
        check("pushpop.grant1", grant1_count, 5);

        run_seg(5);
        idle_cycle();
        check("hold.outstanding", 32'(outstanding), 5);
        check("hold.grant0", grant0_count, 7);
        check("hold.grant1", grant1_count, 7);

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #2;
        check("midrst.outstanding", 32'(outstanding), 0);
        check("midrst.grant0", grant0_count, 0);
        check("midrst.grant1", grant1_count, 0);
        check("midrst.underflow", resp_underflow_count, 0);
        reset = 1'b0;

        run_seg(6);
        idle_cycle();
        check("post.underflow", resp_underflow_count, 1);
        check("post.outstanding", 32'(outstanding), 0);
        check("post.grant0", grant0_count, 0);
        check("post.grant1", grant1_count, 0);
        check("post.mismatch", size_mismatch_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mem_req_arbiter_rr.md
MEM_REQ_ARBITER_RR -- requirements
Module: mem_req_arbiter_rr

Interface
REQ-001 SHALL have parameter ORDER_DEPTH, default 8, number of outstanding requests tracked in the order FIFO (power of 2, 2..64).
REQ-002 SHALL have parameter CW, default $clog2(ORDER_DEPTH)+1, width of the outstanding count.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports s0_req_valid / s1_req_valid  input  1  source request valid.
REQ-006 SHALL have ports s0_req_is_dram / s1_req_is_dram  input  1  request target (1=DRAM, 0=SRAM).
REQ-007 SHALL have ports s0_req_size_bytes / s1_req_size_bytes  input  16  request size.
REQ-008 SHALL have ports s0_req_ready / s1_req_ready  output  1  source accept.
REQ-009 SHALL have ports m_req_valid, m_req_is_dram, m_req_size_bytes  output  1/1/16  request to latency injector.
REQ-010 SHALL have port m_req_ready  input  1  injector accept.
REQ-011 SHALL have ports m_resp_valid, m_resp_size_bytes  input  1/16  in-order injector response.
REQ-012 SHALL have ports s0_resp_valid / s1_resp_valid  output  1  routed response pulse.
REQ-013 SHALL have ports s0_resp_size_bytes / s1_resp_size_bytes  output  16  routed response size.
REQ-014 SHALL have port outstanding  output  CW  order FIFO occupancy.
REQ-015 SHALL have ports grant0_count, grant1_count, resp_underflow_count, size_mismatch_count  output  32 each  statistics.

Function
REQ-016 Request path SHALL be combinational: full = (outstanding == ORDER_DEPTH); m_req_valid = (s0_req_valid | s1_req_valid) & !full.
REQ-017 Grant SHALL be round-robin: if both valid, grant the source other than last_grant; if one valid, grant it; m_req_is_dram/m_req_size_bytes SHALL mux from the granted source (0 when none valid).
REQ-018 sN_req_ready SHALL = m_req_ready & !full & (granted source == N); the non-granted source SHALL see ready=0.
REQ-019 Transfer SHALL occur when m_req_valid & m_req_ready; on transfer push {src_id, size} into the order FIFO, set last_grant = granted source, increment grantN_count.
REQ-020 Grant SHALL be held stable while m_req_valid & !m_req_ready (no switch of last_grant without a transfer).
REQ-021 When full, no push SHALL occur even if a pop occurs in the same cycle (full evaluated on registered occupancy).
REQ-022 On m_resp_valid with FIFO non-empty: pop head; next cycle assert s{src_id}_resp_valid for exactly 1 cycle with sN_resp_size_bytes = m_resp_size_bytes; other source resp_valid = 0.
REQ-023 If m_resp_size_bytes != head size, size_mismatch_count SHALL increment; response still routed.
REQ-024 On m_resp_valid with FIFO empty (including same-cycle push into empty FIFO): resp_underflow_count SHALL increment, no pop, no resp pulse; a same-cycle push SHALL still complete.
REQ-025 Simultaneous push and pop SHALL leave outstanding unchanged; pointers wrap modulo ORDER_DEPTH.
REQ-026 All 32-bit counters SHALL saturate at 0xFFFFFFFF.
REQ-027 Response latency SHALL be exactly 1 cycle from m_resp_valid to sN_resp_valid; back-to-back responses SHALL produce back-to-back pulses.

Reset
REQ-028 On reset: FIFO pointers and outstanding = 0, last_grant = 1 (source 0 wins first contention), all counters = 0, sN_resp_valid = 0, sN_resp_size_bytes = 0.
REQ-029 Reset mid-operation SHALL discard all outstanding entries; responses arriving after reset deassertion SHALL count as underflow.

Verification
REQ-030 Both sources valid continuously, m_req_ready=1, no responses -> grants alternate 0,1,0,1...; after 8 cycles outstanding=8, full, both ready=0, grant0_count=4, grant1_count=4.
REQ-031 Push order src 0(size 16),1(32),0(64), then three m_resp_valid with sizes 16,32,64 -> s0, s1, s0 resp pulses 1 cycle after each, sizes match; size_mismatch_count=0; outstanding=0.
REQ-032 m_resp_valid with empty FIFO -> resp_underflow_count=1, no resp pulse, outstanding stays 0.
REQ-033 FIFO full (8) with simultaneous request and response -> pop only, outstanding=7, no grant, grant counts unchanged.
REQ-034 One outstanding entry with size 96, response size 48 -> routed with size 48, size_mismatch_count=1.
REQ-035 Reset asserted with 5 outstanding, then 1 response after release -> outstanding=0, resp_underflow_count=1, all grant counts 0.
